// File: rtl/osc_count_sequencer.sv
// Reference-clock sequencer for the oscillator frequency counter: gate/settle/evaluate loop that trims the current-source code.
// Optional coarse binary search of the code is enabled by defining OSC_SEQ_COARSE_SEARCH_EN.
module osc_count_sequencer #(
    parameter int CNT_W         = 8,
    parameter int CODE_W        = 6,
    parameter int WINDOW_CYCLES = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_HITS     = 4,
    parameter int CODE_INIT     = 32
) (
    input  logic              clk,
    input  logic              internal_rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  target,
    input  logic [3:0]        tolerance,
    input  logic [CNT_W-1:0]  counter_in,
    output logic              count_done,
    output logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  last_count,
    output logic              meas_valid,
    output logic              locked,
    output logic              sat
);

    localparam int TMR_W = $clog2(WINDOW_CYCLES + SETTLE_CYCLES + 8);
    localparam int HIT_W = $clog2(LOCK_HITS + 1);
    localparam logic [TMR_W-1:0]  CLEAR_LAST  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]        MAX_RETRY   = 2'd3;
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_RST    = CODE_W'(CODE_INIT);
    localparam logic [HIT_W-1:0]  HITS_FULL   = HIT_W'(LOCK_HITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_EVAL   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [TMR_W-1:0]  w_next_tmr;
    logic [1:0]        r_retry;
    logic [1:0]        w_next_retry;
    logic              w_take_sample;
    logic [CNT_W-1:0]  r_sample;
    logic              r_count_done;
    logic              r_meas_valid;
    logic [CNT_W-1:0]  r_last_count;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_next_code;
    logic [HIT_W-1:0]  r_hits;
    logic [HIT_W-1:0]  w_next_hits;
    logic              r_locked;
    logic              w_next_locked;
    logic              r_sat;
    logic              w_next_sat;

    logic [CNT_W:0]    w_diff;
    logic [CNT_W:0]    w_abs;
    logic              w_in_tol;
    logic [CODE_W-1:0] w_trk_code;
    logic [HIT_W-1:0]  w_trk_hits;
    logic              w_trk_locked;
    logic              w_trk_sat;

    assign count_done = r_count_done;
    assign code       = r_code;
    assign last_count = r_last_count;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign sat        = r_sat;

    // Sequencer next-state, phase timer and settle retry control.
    always_comb begin
        w_next_state  = r_state;
        w_next_tmr    = r_tmr + TMR_W'(1);
        w_next_retry  = r_retry;
        w_take_sample = 1'b0;
        if (!enable) begin
            w_next_state = S_IDLE;
            w_next_tmr   = '0;
            w_next_retry = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_CLEAR;
                    w_next_tmr   = '0;
                end
                S_CLEAR: begin
                    if (r_tmr == CLEAR_LAST) begin
                        w_next_state = S_GATE;
                        w_next_tmr   = '0;
                    end else begin
                        w_next_state = S_CLEAR;
                    end
                end
                S_GATE: begin
                    if (r_tmr == WIN_LAST) begin
                        w_next_state = S_SETTLE;
                        w_next_tmr   = '0;
                        w_next_retry = 2'd0;
                    end else begin
                        w_next_state = S_GATE;
                    end
                end
                S_SETTLE: begin
                    // Two consecutive samples must agree; a bounded number of retries guards against a moving count.
                    if (r_tmr >= SETTLE_LAST) begin
                        if ((counter_in != r_sample) && (r_retry < MAX_RETRY)) begin
                            w_next_retry = r_retry + 2'd1;
                        end else begin
                            w_take_sample = 1'b1;
                            w_next_state  = S_EVAL;
                            w_next_tmr    = '0;
                        end
                    end else begin
                        w_next_state = S_SETTLE;
                    end
                end
                S_EVAL: begin
                    w_next_state = S_CLEAR;
                    w_next_tmr   = '0;
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_tmr   = '0;
                end
            endcase
        end
    end

    // Sequencer state, timer, sample and strobe registers.
    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_retry      <= 2'd0;
            r_sample     <= '0;
            r_count_done <= 1'b1;
            r_meas_valid <= 1'b0;
            r_last_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_tmr        <= w_next_tmr;
            r_retry      <= w_next_retry;
            r_sample     <= counter_in;
            r_count_done <= (w_next_state != S_GATE);
            r_meas_valid <= (w_next_state == S_EVAL);
            r_last_count <= w_take_sample ? counter_in : r_last_count;
        end
    end

    assign w_diff   = {1'b0, r_last_count} - {1'b0, target};
    assign w_abs    = w_diff[CNT_W] ? (~w_diff + {{CNT_W{1'b0}}, 1'b1}) : w_diff;
    assign w_in_tol = (w_abs <= {{(CNT_W-3){1'b0}}, tolerance});

    // Normal +/-1 tracking decision with saturation at both code limits.
    always_comb begin
        w_trk_code   = r_code;
        w_trk_hits   = r_hits;
        w_trk_locked = r_locked;
        w_trk_sat    = r_sat;
        if (w_in_tol) begin
            w_trk_hits   = (r_hits < HITS_FULL) ? (r_hits + HIT_W'(1)) : r_hits;
            w_trk_locked = (w_trk_hits == HITS_FULL);
            w_trk_sat    = 1'b0;
        end else begin
            w_trk_hits   = '0;
            w_trk_locked = 1'b0;
            if (w_diff[CNT_W]) begin
                if (r_code == CODE_MAX) begin
                    w_trk_sat = 1'b1;
                end else begin
                    w_trk_code = r_code + CODE_W'(1);
                    w_trk_sat  = 1'b0;
                end
            end else begin
                if (r_code == '0) begin
                    w_trk_sat = 1'b1;
                end else begin
                    w_trk_code = r_code - CODE_W'(1);
                    w_trk_sat  = 1'b0;
                end
            end
        end
    end

`ifdef OSC_SEQ_COARSE_SEARCH_EN
    localparam int SB_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
    localparam logic [SB_W-1:0]   BIT_TOP  = SB_W'(CODE_W - 1);

    logic              r_search_active;
    logic [SB_W-1:0]   r_search_bit;
    logic [CODE_W-1:0] w_srch_code;

    // One binary-search decision: drop the trial bit when the oscillator is fast, then trial the next bit.
    always_comb begin
        w_srch_code = r_code;
        if (r_last_count < target) begin
            w_srch_code = r_code;
        end else begin
            w_srch_code[r_search_bit] = 1'b0;
        end
        if (r_search_bit != '0) begin
            w_srch_code[r_search_bit - SB_W'(1)] = 1'b1;
        end else begin
            w_srch_code = w_srch_code;
        end
    end

    // Search progress: restarted whenever the loop leaves IDLE.
    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            r_search_active <= 1'b1;
            r_search_bit    <= BIT_TOP;
        end else if (enable && (r_state == S_IDLE)) begin
            r_search_active <= 1'b1;
            r_search_bit    <= BIT_TOP;
        end else if (enable && (r_state == S_EVAL) && r_search_active) begin
            r_search_active <= (r_search_bit != '0);
            r_search_bit    <= (r_search_bit != '0) ? (r_search_bit - SB_W'(1)) : r_search_bit;
        end else begin
            r_search_active <= r_search_active;
            r_search_bit    <= r_search_bit;
        end
    end
`endif

    // Select the loop update applied at the end of this cycle.
    always_comb begin
        w_next_code   = r_code;
        w_next_hits   = r_hits;
        w_next_locked = r_locked;
        w_next_sat    = r_sat;
        if (!enable) begin
            w_next_hits   = '0;
            w_next_locked = 1'b0;
        end else if (r_state == S_EVAL) begin
`ifdef OSC_SEQ_COARSE_SEARCH_EN
            if (r_search_active) begin
                w_next_code   = w_srch_code;
                w_next_hits   = '0;
                w_next_locked = 1'b0;
            end else begin
                w_next_code   = w_trk_code;
                w_next_hits   = w_trk_hits;
                w_next_locked = w_trk_locked;
                w_next_sat    = w_trk_sat;
            end
`else
            w_next_code   = w_trk_code;
            w_next_hits   = w_trk_hits;
            w_next_locked = w_trk_locked;
            w_next_sat    = w_trk_sat;
`endif
        end else if (r_state == S_IDLE) begin
`ifdef OSC_SEQ_COARSE_SEARCH_EN
            w_next_code = CODE_MID;
            w_next_hits = '0;
`else
            w_next_code = r_code;
`endif
        end else begin
            w_next_code = r_code;
        end
    end

    // Loop result registers: code, lock tracking and saturation flag.
    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            r_code   <= CODE_RST;
            r_hits   <= '0;
            r_locked <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_code   <= w_next_code;
            r_hits   <= w_next_hits;
            r_locked <= w_next_locked;
            r_sat    <= w_next_sat;
        end
    end

endmodule
